z80_bus_ctrl: RTL and testbench
===============================

Name: z80_bus_ctrl

Overview:
- Parametrised machine-cycle sequencer for the z80 core.
- Converts single-beat requests from the control path into T-state-accurate bus cycles: opcode fetch (M1), memory read/write, I/O read/write.
- Drives the address bus, data bus and strobes; samples WAIT_L; returns read data.
- Sits between control path/datapath and the top-level bus pins; the top instantiates it and owns the tristate buffers.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data bus width.
- IO_WAIT, 1, automatic wait states inserted in every I/O cycle (0..3).
- RFSH_W, 7, width of the refresh counter field placed on the low address bits.

Ports:
- CLK  in  1  core clock; all logic on rising edge.
- RESET_L  in  1  synchronous, active-low reset.
- req_valid  in  1  control path presents a request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  3  bus_op_t: FETCH, MEM_RD, MEM_WR, IO_RD, IO_WR.
- req_addr  in  ADDR_W  cycle address.
- req_wdata  in  DATA_W  write data.
- rfsh_addr  in  ADDR_W  refresh address {I, R} from datapath.
- rsp_valid  out  1  one-cycle pulse with read/fetch data.
- rsp_rdata  out  DATA_W  latched read data.
- addr_out  out  ADDR_W  address to bus buffer.
- addr_oe  out  1  address drive enable.
- data_in  in  DATA_W  data bus sample.
- data_out  out  DATA_W  write data to bus buffer.
- data_oe  out  1  data drive enable.
- WAIT_L  in  1  memory/I/O wait request.
- M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L  out  1 each  bus strobes, active-low.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset values:
  - All strobes 1.
  - addr_oe = 0, data_oe = 0.
  - addr_out = 0, data_out = 0, rsp_rdata = 0.
  - rsp_valid = 0, busy = 0.
  - State IDLE.
- Reset is sampled every edge. Reset mid-cycle aborts the cycle: next state IDLE, all strobes released on that edge, no rsp_valid.
- States: IDLE, T1, T2, TW, T3, T4. All outputs are registered and reflect the current state.
- req_ready is 1 in IDLE and in the final T-state of a cycle (T3 for non-fetch, T4 for fetch). An accepted request moves to T1 on the next edge, giving gapless back-to-back cycles. Otherwise the final state returns to IDLE.
- Transitions:
  - T1 -> T2.
  - T2 -> TW if WAIT_L = 0 or auto-wait count > 0; else T3 (MEM/IO) or T3 fetch-sample (FETCH).
  - TW -> TW while WAIT_L = 0 or auto-wait count > 0.
  - T3 -> T4 (FETCH only).
- Auto-wait: a counter loads IO_WAIT at T1 for IO ops and decrements in T2/TW. WAIT_L is sampled only after the count reaches 0. Memory ops load 0.
- MEM_RD:
  - addr_oe = 1 T1..T3.
  - MREQ_L = RD_L = 0 T1..T3.
  - data_in latched on the edge leaving T3; rsp_valid pulses the following cycle.
  - Latency from accept: 4 cycles plus waits.
- MEM_WR:
  - MREQ_L = 0 T1..T3; data_oe = 1 T1..T3.
  - WR_L = 0 T2..T3 (including TW).
  - No rsp_valid.
- IO_RD / IO_WR: as MEM_RD / MEM_WR, with IORQ_L instead of MREQ_L. IORQ_L asserts from T2, not T1.
- FETCH:
  - M1_L = MREQ_L = RD_L = 0 T1..T2/TW.
  - data_in latched on the edge leaving the last T2/TW; rsp_valid pulses during T3.
  - T3..T4 behaviour is per the optional feature.
- Write data is captured at accept and held stable T1..T3 even if req_wdata changes.
- req_addr is captured at accept; addr_out holds stable for the whole cycle.
- WAIT_L is ignored in T1, T3 and T4.

Optional Feature:
- Macro Z80_RFSH_EN.
- Defined:
  - In FETCH T3..T4: addr_out = rfsh_addr with low RFSH_W bits.
  - RFSH_L = 0 T3..T4.
  - MREQ_L = 0 in T3 only.
- Undefined:
  - RFSH_L tied 1; addr_oe = 0 in T3..T4.
  - FETCH still takes 4 T-states, so timing is identical.

Decomposition:
- Package z80_pkg holds:
  - bus_op_t enum.
  - tstate_t enum (IDLE, T1, T2, TW, T3, T4).
  - Localparam MAX_IO_WAIT = 3.
- One sub-module, z80_wait_ctr: loadable down-counter plus WAIT_L qualify; outputs stall.

Test Plan:
- MEM_RD addr 0x1234, WAIT_L = 1, data_in = 0xA5 -> MREQ_L/RD_L low exactly 3 cycles; rsp_valid one cycle later with rsp_rdata = 0xA5.
- MEM_WR addr 0x8000, data 0x3C, WAIT_L low for 2 cycles in T2 -> WR_L low 4 cycles; data_out = 0x3C with data_oe high T1..T3 (5 cycles total).
- IO_RD port 0x00FE, IO_WAIT = 1, WAIT_L = 1 -> IORQ_L low T2..T3 with one TW; total 4 cycles; MREQ_L never asserted.
- FETCH 0x0000 then FETCH 0x0001 back-to-back, rfsh_addr = 0x0042 -> second T1 immediately follows T4. With Z80_RFSH_EN: addr_out = 0x0042 and RFSH_L low in T3..T4.
- RESET_L low during TW of MEM_WR -> next edge: all strobes 1, data_oe = 0, busy = 0, no rsp_valid.
- req_valid held with req_ready low in T2 -> request not accepted until final T-state; no duplicate cycle issued.

Source files
------------

// File: rtl/z80_pkg.sv
// Shared types for the z80 bus sequencer: bus operations, T-states, wait limits
// and small operation classifiers.
package z80_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      MEM_RD = 3'd1,
      MEM_WR = 3'd2,
      IO_RD  = 3'd3,
      IO_WR  = 3'd4
   } bus_op_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      TW   = 3'd3,
      T3   = 3'd4,
      T4   = 3'd5
   } tstate_t;

   localparam int unsigned MAX_IO_WAIT = 3;
   localparam int unsigned WAIT_CNT_W  = 2;

   function automatic logic op_is_io(input bus_op_t op);
      return (op == IO_RD) || (op == IO_WR);
   endfunction

   function automatic logic op_is_wr(input bus_op_t op);
      return (op == MEM_WR) || (op == IO_WR);
   endfunction

   function automatic logic op_is_rd(input bus_op_t op);
      return (op == MEM_RD) || (op == IO_RD);
   endfunction

endpackage

// File: rtl/z80_wait_ctr.sv
// Wait-state qualifier: loadable down-counter for automatic I/O waits, with the
// external WAIT_L request honoured only once the count has expired.
module z80_wait_ctr
   import z80_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET_L,
   input  logic                  i_load,
   input  logic [WAIT_CNT_W-1:0] i_load_val,
   input  logic                  i_dec,
   input  logic                  i_wait_l,
   output logic                  o_stall
);

   logic [WAIT_CNT_W-1:0] r_cnt;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_stall = (r_cnt != '0) || !i_wait_l;

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 machine-cycle sequencer: turns single-beat requests into T-state bus cycles.
// Define Z80_RFSH_EN to drive the refresh address and RFSH_L during fetch T3..T4.
module z80_bus_ctrl
   import z80_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned IO_WAIT = 1,
   parameter int unsigned RFSH_W  = 7
)(
   input  logic              CLK,
   input  logic              RESET_L,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [ADDR_W-1:0] rfsh_addr,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_oe,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   input  logic              WAIT_L,
   output logic              M1_L,
   output logic              MREQ_L,
   output logic              IORQ_L,
   output logic              RD_L,
   output logic              WR_L,
   output logic              RFSH_L,
   output logic              busy
);

   localparam logic [WAIT_CNT_W-1:0] IO_WAIT_LD =
      WAIT_CNT_W'((IO_WAIT > MAX_IO_WAIT) ? MAX_IO_WAIT : IO_WAIT);

   tstate_t           r_state, w_state_nxt;
   bus_op_t           r_op, w_op_nxt;
   logic              w_accept, w_stall, w_sample;
   logic              w_fetch, w_io, w_wr;
   logic              w_m1_l, w_mreq_l, w_iorq_l, w_rd_l, w_wr_l, w_rfsh_l;
   logic              w_addr_oe, w_data_oe, w_ready;
   logic              r_m1_l, r_mreq_l, r_iorq_l, r_rd_l, r_wr_l, r_rfsh_l;
   logic              r_addr_oe, r_data_oe, r_req_ready, r_rsp_valid, r_busy;
   logic [ADDR_W-1:0] r_addr_out, w_rfsh_mix;
   logic [DATA_W-1:0] r_data_out, r_rsp_rdata;

   // {I, R}: the refresh counter field sits in the low RFSH_W bits.
   assign w_rfsh_mix = {rfsh_addr[ADDR_W-1:RFSH_W], rfsh_addr[RFSH_W-1:0]};
`ifndef Z80_RFSH_EN
   logic w_unused_rfsh;
   assign w_unused_rfsh = ^w_rfsh_mix;
`endif

   z80_wait_ctr u_wait_ctr (
      .CLK        (CLK),
      .RESET_L    (RESET_L),
      .i_load     (r_state == T1),
      .i_load_val (op_is_io(r_op) ? IO_WAIT_LD : '0),
      .i_dec      ((r_state == T2) || (r_state == TW)),
      .i_wait_l   (WAIT_L),
      .o_stall    (w_stall)
   );

   assign w_accept = req_valid && r_req_ready;
   assign w_op_nxt = w_accept ? bus_op_t'(req_op) : r_op;
   assign w_sample = (((r_state == T2) || (r_state == TW)) && (r_op == FETCH) && !w_stall)
                   || ((r_state == T3) && op_is_rd(r_op));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = T1;
         T1:      w_state_nxt = T2;
         T2, TW:  w_state_nxt = w_stall ? TW : T3;
         T3:      w_state_nxt = (r_op == FETCH) ? T4 : (w_accept ? T1 : IDLE);
         T4:      w_state_nxt = w_accept ? T1 : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so pins are glitch-free.
   always_comb begin
      // NOTE: every output gets a default first, otherwise unlisted states infer latches.
      w_m1_l    = 1'b1;
      w_mreq_l  = 1'b1;
      w_iorq_l  = 1'b1;
      w_rd_l    = 1'b1;
      w_wr_l    = 1'b1;
      w_rfsh_l  = 1'b1;
      w_addr_oe = 1'b0;
      w_data_oe = 1'b0;
      w_ready   = 1'b0;
      w_fetch   = (w_op_nxt == FETCH);
      w_io      = op_is_io(w_op_nxt);
      w_wr      = op_is_wr(w_op_nxt);
      case (w_state_nxt)
         IDLE: w_ready = 1'b1;
         T1: begin
            w_addr_oe = 1'b1;
            w_m1_l    = !w_fetch;
            w_mreq_l  = w_io;
            w_rd_l    = w_wr;
            w_data_oe = w_wr;
         end
         T2, TW: begin
            w_addr_oe = 1'b1;
            w_m1_l    = !w_fetch;
            w_mreq_l  = w_io;
            w_iorq_l  = !w_io;
            w_rd_l    = w_wr;
            w_wr_l    = !w_wr;
            w_data_oe = w_wr;
         end
         T3: begin
            if (!w_fetch) begin
               w_addr_oe = 1'b1;
               w_mreq_l  = w_io;
               w_iorq_l  = !w_io;
               w_rd_l    = w_wr;
               w_wr_l    = !w_wr;
               w_data_oe = w_wr;
               w_ready   = 1'b1;
            end else begin
`ifdef Z80_RFSH_EN
               w_addr_oe = 1'b1;
               w_mreq_l  = 1'b0;
               w_rfsh_l  = 1'b0;
`endif
            end
         end
         T4: begin
            w_ready = 1'b1;
`ifdef Z80_RFSH_EN
            w_addr_oe = 1'b1;
            w_rfsh_l  = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         r_state     <= IDLE;
         r_op        <= FETCH;
         r_m1_l      <= 1'b1;
         r_mreq_l    <= 1'b1;
         r_iorq_l    <= 1'b1;
         r_rd_l      <= 1'b1;
         r_wr_l      <= 1'b1;
         r_rfsh_l    <= 1'b1;
         r_addr_oe   <= 1'b0;
         r_data_oe   <= 1'b0;
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_addr_out  <= '0;
         r_data_out  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_op        <= w_op_nxt;
         r_m1_l      <= w_m1_l;
         r_mreq_l    <= w_mreq_l;
         r_iorq_l    <= w_iorq_l;
         r_rd_l      <= w_rd_l;
         r_wr_l      <= w_wr_l;
         r_rfsh_l    <= w_rfsh_l;
         r_addr_oe   <= w_addr_oe;
         r_data_oe   <= w_data_oe;
         r_req_ready <= w_ready;
         r_busy      <= (w_state_nxt != IDLE);
         r_rsp_valid <= w_sample;
         if (w_sample) r_rsp_rdata <= data_in;
         if (w_accept) begin
            r_addr_out <= req_addr;
            if (op_is_wr(bus_op_t'(req_op))) r_data_out <= req_wdata;
         end
`ifdef Z80_RFSH_EN
         else if ((w_state_nxt == T3) && (r_op == FETCH)) begin
            r_addr_out <= w_rfsh_mix;
         end
`endif
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign addr_out  = r_addr_out;
   assign addr_oe   = r_addr_oe;
   assign data_out  = r_data_out;
   assign data_oe   = r_data_oe;
   assign M1_L      = r_m1_l;
   assign MREQ_L    = r_mreq_l;
   assign IORQ_L    = r_iorq_l;
   assign RD_L      = r_rd_l;
   assign WR_L      = r_wr_l;
   assign RFSH_L    = r_rfsh_l;
   assign busy      = r_busy;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Self-checking bench for z80_bus_ctrl: a per-cycle expected timeline is built
// from bus-cycle rules for directed and random requests, then replayed on the DUT.
module tb_z80_bus_ctrl;
   import z80_pkg::*;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;
   localparam int IO_WAIT = 1;
   localparam int RFSH_W  = 7;
   localparam int MAXC    = 1024;
`ifdef Z80_RFSH_EN
   localparam bit RFSH = 1'b1;
`else
   localparam bit RFSH = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RESET_L;
   logic              req_valid, req_ready;
   logic [2:0]        req_op;
   logic [ADDR_W-1:0] req_addr, rfsh_addr, addr_out;
   logic [DATA_W-1:0] req_wdata, rsp_rdata, data_in, data_out;
   logic              rsp_valid, addr_oe, data_oe, WAIT_L, busy;
   logic              M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;

   always #5 CLK = ~CLK;

   z80_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IO_WAIT(IO_WAIT), .RFSH_W(RFSH_W)) dut (
      .CLK(CLK), .RESET_L(RESET_L), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .rfsh_addr(rfsh_addr),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .addr_out(addr_out), .addr_oe(addr_oe),
      .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .WAIT_L(WAIT_L),
      .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
      .RFSH_L(RFSH_L), .busy(busy)
   );

   // Stimulus timeline: inputs present during cycle t are sampled by the edge ending it.
   bit                in_valid [MAXC];
   logic [2:0]        in_op    [MAXC];
   logic [ADDR_W-1:0] in_addr  [MAXC];
   logic [ADDR_W-1:0] in_rfsh  [MAXC];
   logic [DATA_W-1:0] in_wdata [MAXC];
   logic [DATA_W-1:0] in_data  [MAXC];
   bit                in_wait  [MAXC];
   // Expected outputs during cycle t; strobes are {M1,MREQ,IORQ,RD,WR,RFSH} active-low.
   logic [5:0]        exp_strb [MAXC];
   bit                exp_aoe  [MAXC];
   bit                exp_doe  [MAXC];
   bit                exp_busy [MAXC];
   bit                exp_rdy  [MAXC];
   bit                exp_rv   [MAXC];
   logic [ADDR_W-1:0] exp_addr [MAXC];
   logic [DATA_W-1:0] exp_dout [MAXC];
   logic [DATA_W-1:0] rsp_d    [MAXC];
   logic [DATA_W-1:0] exp_rd   [MAXC];

   int n_chk = 0;
   int n_err = 0;
   int last_end = 0;
   int prev_t1 = 0;
   int n_txn = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Place one request on the timeline and derive its expected bus cycle.
   task automatic add_txn(input bus_op_t op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                          input logic [ADDR_W-1:0] rfsh, input int k_wait,
                          input int gap, input bit early);
      int  t_acc, t1, t3, t_end, t_smp, auto_w, nw, t_from;
      bit  fetch, io, wr;
      bit  m1, mreq, iorq, rdl, wrl, rf;
      fetch  = (op == FETCH);
      io     = (op == IO_RD) || (op == IO_WR);
      wr     = (op == MEM_WR) || (op == IO_WR);
      t_acc  = last_end + gap;
      t_from = (early && gap == 0 && n_txn > 0) ? prev_t1 + 1 : t_acc;
      for (int t = t_from; t <= t_acc; t++) begin
         in_valid[t] = 1'b1;
         in_op[t]    = op;
         in_addr[t]  = addr;
         in_wdata[t] = wdata;
      end
      auto_w = io ? IO_WAIT : 0;
      nw     = auto_w + k_wait;
      t1     = t_acc + 1;
      t3     = t1 + 2 + nw;
      t_end  = fetch ? t3 + 1 : t3;
      for (int j = auto_w; j <= nw; j++) in_wait[t1 + 1 + j] = (j == nw);
      for (int t = t1; t <= t_end; t++) begin
         in_rfsh[t]  = rfsh;
         exp_busy[t] = 1'b1;
         exp_rdy[t]  = (t == t_end);
         rf = 1'b0; m1 = 1'b0; iorq = 1'b0; wrl = 1'b0;
         if (fetch) begin
            m1          = (t < t3);
            mreq        = (t < t3) || (RFSH && t == t3);
            rdl         = (t < t3);
            rf          = RFSH && (t >= t3);
            exp_aoe[t]  = (t < t3) || RFSH;
            exp_doe[t]  = 1'b0;
            exp_addr[t] = (t < t3) ? addr : rfsh;
         end else begin
            mreq        = !io;
            iorq        = io && (t > t1);
            rdl         = !wr;
            wrl         = wr && (t > t1);
            exp_aoe[t]  = 1'b1;
            exp_doe[t]  = wr;
            exp_addr[t] = addr;
         end
         exp_dout[t] = wdata;
         exp_strb[t] = ~{m1, mreq, iorq, rdl, wrl, rf};
      end
      if (!wr) begin
         t_smp = fetch ? t3 - 1 : t3;
         in_data[t_smp]   = rdata;
         exp_rv[t_smp + 1] = 1'b1;
         rsp_d[t_smp + 1]  = rdata;
      end
      last_end = t_end;
      prev_t1  = t1;
      n_txn++;
   endtask

   initial begin
      logic [DATA_W-1:0] cur;
      int n_cyc;
      for (int t = 0; t < MAXC; t++) begin
         in_valid[t] = 1'b0;
         in_op[t]    = 3'($urandom_range(0, 4));
         in_addr[t]  = ADDR_W'($urandom);
         in_rfsh[t]  = ADDR_W'($urandom);
         in_wdata[t] = DATA_W'($urandom);
         in_data[t]  = DATA_W'($urandom);
         in_wait[t]  = 1'($urandom);
         exp_strb[t] = 6'h3F;
         exp_aoe[t]  = 1'b0;
         exp_doe[t]  = 1'b0;
         exp_busy[t] = 1'b0;
         exp_rdy[t]  = 1'b1;
         exp_rv[t]   = 1'b0;
         exp_addr[t] = '0;
         exp_dout[t] = '0;
         rsp_d[t]    = '0;
      end

      add_txn(MEM_RD, 16'h1234, 8'h00, 8'hA5, 16'h0000, 0, 1, 1'b0);
      add_txn(MEM_WR, 16'h8000, 8'h3C, 8'h00, 16'h0000, 2, 1, 1'b0);
      add_txn(IO_RD,  16'h00FE, 8'h00, 8'h5A, 16'h0000, 0, 1, 1'b0);
      add_txn(FETCH,  16'h0000, 8'h00, 8'hC3, 16'h0042, 0, 1, 1'b0);
      add_txn(FETCH,  16'h0001, 8'h00, 8'h3E, 16'h0042, 0, 0, 1'b1);
      add_txn(MEM_RD, 16'h4321, 8'h00, 8'h7E, 16'h0000, 1, 0, 1'b1);
      while (n_txn < 80 && last_end < MAXC - 40) begin
         add_txn(bus_op_t'($urandom_range(0, 4)), ADDR_W'($urandom), DATA_W'($urandom),
                 DATA_W'($urandom), ADDR_W'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 2), 1'($urandom));
      end
      n_cyc = last_end + 3;

      cur = '0;
      for (int t = 0; t < MAXC; t++) begin
         if (exp_rv[t]) cur = rsp_d[t];
         exp_rd[t] = cur;
      end

      RESET_L = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
      rfsh_addr = '0; data_in = '0; WAIT_L = 1'b1;
      repeat (3) @(posedge CLK);

      for (int t = 0; t < n_cyc; t++) begin
         @(negedge CLK);
         if (t == 0) begin
            check("rst_addr_out", 32'(addr_out), 32'h0);
            check("rst_data_out", 32'(data_out), 32'h0);
         end
         check($sformatf("c%0d strobes", t), 32'({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}),
               32'(exp_strb[t]));
         check($sformatf("c%0d addr_oe", t), 32'(addr_oe), 32'(exp_aoe[t]));
         check($sformatf("c%0d data_oe", t), 32'(data_oe), 32'(exp_doe[t]));
         check($sformatf("c%0d busy", t), 32'(busy), 32'(exp_busy[t]));
         check($sformatf("c%0d req_ready", t), 32'(req_ready), 32'(exp_rdy[t]));
         check($sformatf("c%0d rsp_valid", t), 32'(rsp_valid), 32'(exp_rv[t]));
         check($sformatf("c%0d rsp_rdata", t), 32'(rsp_rdata), 32'(exp_rd[t]));
         if (exp_aoe[t]) check($sformatf("c%0d addr_out", t), 32'(addr_out), 32'(exp_addr[t]));
         if (exp_doe[t]) check($sformatf("c%0d data_out", t), 32'(data_out), 32'(exp_dout[t]));
         RESET_L   = 1'b1;
         req_valid = in_valid[t];
         req_op    = in_op[t];
         req_addr  = in_addr[t];
         req_wdata = in_wdata[t];
         rfsh_addr = in_rfsh[t];
         data_in   = in_data[t];
         WAIT_L    = in_wait[t];
      end

      // Reset asserted during a MEM_WR wait state must abort the cycle outright.
      @(negedge CLK);
      req_valid = 1'b1; req_op = MEM_WR; req_addr = 16'h8000; req_wdata = 8'h3C; WAIT_L = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0; WAIT_L = 1'b0;
      @(negedge CLK);
      WAIT_L = 1'b0;
      @(negedge CLK);
      check("abort_pre WR_L", 32'(WR_L), 32'h0);
      check("abort_pre busy", 32'(busy), 32'h1);
      check("abort_pre data_out", 32'(data_out), 32'h3C);
      RESET_L = 1'b0;
      @(negedge CLK);
      check("abort strobes", 32'({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}), 32'h3F);
      check("abort data_oe", 32'(data_oe), 32'h0);
      check("abort addr_oe", 32'(addr_oe), 32'h0);
      check("abort busy", 32'(busy), 32'h0);
      check("abort rsp_valid", 32'(rsp_valid), 32'h0);
      RESET_L = 1'b1; WAIT_L = 1'b1;
      @(negedge CLK);
      check("post_abort busy", 32'(busy), 32'h0);
      check("post_abort strobes", 32'({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}), 32'h3F);
      check("post_abort rsp_valid", 32'(rsp_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
